// File: rtl/stack_cpu_core.sv
// Stack-machine CPU core: a fetch/execute FSM with a LIFO operand stack, a carry
// flag and conditional jumps. An instruction takes at least two cycles: FETCH
// waits for the memory acknowledge, and EXEC runs for exactly one cycle.
module stack_cpu_core #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 12
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    output logic [ADDR_W-1:0]       o_imem_addr,
    output logic                    o_imem_req,
    input  logic                    i_imem_ack,
    input  logic [WIDTH+1:0]        i_imem_data,
    output logic [WIDTH-1:0]        o_top,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_carry,
    output logic                    o_halted,
    output logic                    o_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0]     CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]     CNT_TWO  = CW'(2);
    localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] IP_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ip_q, ip_d;
    logic [CW-1:0]       count_q, count_d;
    logic                carry_q, carry_d;
    logic [WIDTH+1:0]    instr_q, instr_d;
    logic [WIDTH-1:0]    stack_q [DEPTH];
    logic [WIDTH-1:0]    stack_d [DEPTH];

    logic [1:0]          instrType;
    logic [WIDTH-1:0]    payload;
    logic [AW-1:0]       topIdx;
    logic [AW-1:0]       secIdx;
    logic [AW-1:0]       pushIdx;
    logic [WIDTH-1:0]    topVal;
    logic [WIDTH-1:0]    secVal;
    logic                faultNow;
    logic                jumpTaken;
    logic [WIDTH:0]      aluRes;

    assign instrType = instr_q[WIDTH+1:WIDTH];
    assign payload   = instr_q[WIDTH-1:0];

    // The stack grows upward: entry count-1 is the top, count-2 the second.
    assign topIdx  = AW'(count_q - CNT_ONE);
    assign secIdx  = AW'(count_q - CNT_TWO);
    assign pushIdx = AW'(count_q);
    assign topVal  = stack_q[topIdx];
    assign secVal  = stack_q[secIdx];

    assign o_imem_addr = ip_q;
    assign o_imem_req  = (state_q == FETCH) && !i_reset;
    assign o_top       = (count_q == CNT_ZERO) ? '0 : topVal;
    assign o_count     = count_q;
    assign o_carry     = carry_q;
    assign o_halted    = (state_q == HALT);
    assign o_fault     = (state_q == FAULT);

    // Next-state logic: fetch handshake, instruction execution, and rollback of
    // every architectural update whenever the instruction faults.
    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        count_d   = count_q;
        carry_d   = carry_q;
        instr_d   = instr_q;
        stack_d   = stack_q;
        faultNow  = 1'b0;
        jumpTaken = 1'b0;
        aluRes    = '0;

        case (state_q)
            FETCH: begin
                if (i_imem_ack) begin
                    instr_d = i_imem_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                ip_d    = ip_q + IP_ONE;
                case (instrType)
                    2'b00: begin
                        if (count_q == CNT_FULL) begin
                            faultNow = 1'b1;
                        end else begin
                            stack_d[pushIdx] = payload;
                            count_d          = count_q + CNT_ONE;
                        end
                    end
                    2'b01: begin
                        case (payload[4:0])
                            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5: begin
                                if (count_q < CNT_TWO) begin
                                    faultNow = 1'b1;
                                end else begin
                                    case (payload[2:0])
                                        3'd0: aluRes = {1'b0, secVal} + {1'b0, topVal};
                                        3'd1: aluRes = {1'b0, secVal} + {1'b0, ~topVal} + {{WIDTH{1'b0}}, 1'b1};
                                        3'd2: aluRes = {1'b0, secVal & topVal};
                                        3'd3: aluRes = {1'b0, secVal | topVal};
                                        3'd4: aluRes = {1'b0, secVal ^ topVal};
                                        default: aluRes = {1'b0, secVal} + {1'b0, topVal} + {{WIDTH{1'b0}}, carry_q};
                                    endcase
                                    stack_d[secIdx] = aluRes[WIDTH-1:0];
                                    count_d         = count_q - CNT_ONE;
                                    if ((payload[2:0] == 3'd0) || (payload[2:0] == 3'd1) || (payload[2:0] == 3'd5)) begin
                                        carry_d = aluRes[WIDTH];
                                    end
                                end
                            end
                            5'd6: begin
                                if ((count_q == CNT_ZERO) || (count_q == CNT_FULL)) begin
                                    faultNow = 1'b1;
                                end else begin
                                    stack_d[pushIdx] = topVal;
                                    count_d          = count_q + CNT_ONE;
                                end
                            end
                            5'd7: begin
                                if (count_q == CNT_ZERO) begin
                                    faultNow = 1'b1;
                                end else begin
                                    count_d = count_q - CNT_ONE;
                                end
                            end
                            5'd8: begin
                                if (count_q < CNT_TWO) begin
                                    faultNow = 1'b1;
                                end else begin
                                    stack_d[topIdx] = secVal;
                                    stack_d[secIdx] = topVal;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                    2'b10: begin
                        case (payload[2:0])
                            3'd0: jumpTaken = 1'b1;
                            3'd1: jumpTaken = (topVal == '0);
                            3'd2: jumpTaken = (topVal != '0);
                            3'd3: jumpTaken = topVal[WIDTH-1];
                            3'd4: jumpTaken = carry_q;
                            default: jumpTaken = 1'b0;
                        endcase
                        if ((payload[2:0] >= 3'd1) && (payload[2:0] <= 3'd3) && (count_q == CNT_ZERO)) begin
                            faultNow = 1'b1;
                        end else if (jumpTaken) begin
                            ip_d = payload[ADDR_W+2:3];
                        end
                    end
                    default: begin
                        if (payload[0]) begin
                            state_d = HALT;
                            ip_d    = ip_q;
                        end
                    end
                endcase

                if (faultNow) begin
                    state_d = FAULT;
                    ip_d    = ip_q;
                    count_d = count_q;
                    carry_d = carry_q;
                    stack_d = stack_q;
                end
            end
            HALT: begin
            end
            default: begin
            end
        endcase
    end

    // Control and architectural registers; synchronous reset aborts any
    // instruction in flight.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= FETCH;
            ip_q    <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            count_q <= count_d;
            carry_q <= carry_d;
            instr_q <= instr_d;
        end
    end

    // Stack storage; entries above the occupancy count are never observed, so
    // they need no reset and are frozen while reset is high.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            stack_q <= stack_d;
        end
    end

endmodule

// File: tb/tb_stack_cpu_core.sv
// Self-checking bench for stack_cpu_core: a table of short programs run to
// HALT/FAULT, plus hand-written sequences for timing and reset corners.
module tb_stack_cpu_core;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [11:0] o_imem_addr;
    logic        o_imem_req;
    logic        i_imem_ack;
    logic [17:0] i_imem_data;
    logic [15:0] o_top;
    logic [4:0]  o_count;
    logic        o_carry;
    logic        o_halted;
    logic        o_fault;

    logic [17:0] progMem [4096];
    logic        ackOn = 1'b1;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [6:0][17:0] prog;
        logic [11:0]      xAddr;
        logic [17:0]      xWord;
        logic [15:0]      expTop;
        logic [4:0]       expCount;
        logic             expCarry;
        logic             expHalted;
        logic             expFault;
        logic [11:0]      expAddr;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    stack_cpu_core #(.WIDTH(16), .DEPTH(16), .ADDR_W(12)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .o_imem_addr (o_imem_addr),
        .o_imem_req  (o_imem_req),
        .i_imem_ack  (i_imem_ack),
        .i_imem_data (i_imem_data),
        .o_top       (o_top),
        .o_count     (o_count),
        .o_carry     (o_carry),
        .o_halted    (o_halted),
        .o_fault     (o_fault)
    );

    // Free-running clock, 10 time-unit period.
    always #5 i_clock = ~i_clock;

    // Zero-latency instruction memory model; ack gated by the stimulus.
    assign i_imem_data = progMem[o_imem_addr];
    assign i_imem_ack  = ackOn;

    function automatic logic [17:0] lit(input logic [15:0] v);
        return {2'b00, v};
    endfunction

    function automatic logic [17:0] alu(input logic [4:0] op);
        return {2'b01, 11'b0, op};
    endfunction

    function automatic logic [17:0] jmp(input logic [2:0] c, input logic [11:0] t);
        return {2'b10, 1'b0, t, c};
    endfunction

    localparam logic [17:0] HLT  = {2'b11, 16'h0001};
    localparam logic [17:0] SNOP = {2'b11, 16'h0000};

    function automatic vec_t mkVec(input logic [17:0] w0, w1, w2, w3, w4, w5, w6,
                                   input logic [11:0] xa, input logic [17:0] xw,
                                   input logic [15:0] top, input logic [4:0] cnt,
                                   input logic cy, input logic hl, input logic ft,
                                   input logic [11:0] ad);
        vec_t v;
        v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2; v.prog[3] = w3;
        v.prog[4] = w4; v.prog[5] = w5; v.prog[6] = w6;
        v.xAddr = xa; v.xWord = xw;
        v.expTop = top; v.expCount = cnt; v.expCarry = cy;
        v.expHalted = hl; v.expFault = ft; v.expAddr = ad;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearMem();
        for (int a = 0; a < 4096; a++) progMem[a] = 18'h0;
    endtask

    task automatic applyReset();
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        checkOutput("reqLowInReset", {31'b0, o_imem_req}, 32'd0);
        @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        checkOutput("resetReq", {31'b0, o_imem_req}, 32'd1);
        checkOutput("resetAddr", {20'b0, o_imem_addr}, 32'd0);
        checkOutput("resetCount", {27'b0, o_count}, 32'd0);
        checkOutput("resetTop", {16'b0, o_top}, 32'd0);
        checkOutput("resetCarry", {31'b0, o_carry}, 32'd0);
        checkOutput("resetFlags", {30'b0, o_halted, o_fault}, 32'd0);
    endtask

    task automatic waitDone(input int budget);
        int c;
        c = 0;
        while (!(o_halted || o_fault) && c < budget) begin
            @(negedge i_clock);
            c++;
        end
        if (!(o_halted || o_fault)) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: got no halt/fault expected halt/fault within %0d cycles", budget);
        end
    endtask

    task automatic applyStimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        ackOn = 1'b1;
        clearMem();
        for (int k = 0; k < 7; k++) progMem[k] = v.prog[k];
        progMem[v.xAddr] = v.xWord;
        applyReset();
        waitDone(200);
        checkOutput($sformatf("v%0d.top", idx), {16'b0, o_top}, {16'b0, v.expTop});
        checkOutput($sformatf("v%0d.count", idx), {27'b0, o_count}, {27'b0, v.expCount});
        checkOutput($sformatf("v%0d.carry", idx), {31'b0, o_carry}, {31'b0, v.expCarry});
        checkOutput($sformatf("v%0d.halted", idx), {31'b0, o_halted}, {31'b0, v.expHalted});
        checkOutput($sformatf("v%0d.fault", idx), {31'b0, o_fault}, {31'b0, v.expFault});
        checkOutput($sformatf("v%0d.addr", idx), {20'b0, o_imem_addr}, {20'b0, v.expAddr});
        checkOutput($sformatf("v%0d.req", idx), {31'b0, o_imem_req}, 32'd0);
    endtask

    // Main sequence: table vectors followed by multi-cycle corner cases.
    initial begin
        vecs[0]  = mkVec(lit(5), lit(7), alu(0), HLT, 0, 0, 0, 12'hFFF, 0, 16'd12, 5'd1, 0, 1, 0, 12'd3);
        vecs[1]  = mkVec(lit(16'hFFFF), lit(1), alu(0), HLT, 0, 0, 0, 12'hFFF, 0, 16'h0000, 5'd1, 1, 1, 0, 12'd3);
        vecs[2]  = mkVec(lit(16'hFFFF), lit(1), alu(0), lit(0), lit(0), alu(5), HLT, 12'hFFF, 0, 16'd1, 5'd2, 0, 1, 0, 12'd6);
        vecs[3]  = mkVec(lit(5), lit(3), alu(1), HLT, 0, 0, 0, 12'hFFF, 0, 16'd2, 5'd1, 1, 1, 0, 12'd3);
        vecs[4]  = mkVec(lit(3), lit(5), alu(1), HLT, 0, 0, 0, 12'hFFF, 0, 16'hFFFE, 5'd1, 0, 1, 0, 12'd3);
        vecs[5]  = mkVec(lit(16'hF0F0), lit(16'hFF00), alu(4), HLT, 0, 0, 0, 12'hFFF, 0, 16'h0FF0, 5'd1, 0, 1, 0, 12'd3);
        vecs[6]  = mkVec(lit(16'h00F0), lit(16'h0F0F), alu(3), lit(16'h00FF), alu(2), HLT, 0, 12'hFFF, 0, 16'h00FF, 5'd1, 0, 1, 0, 12'd5);
        vecs[7]  = mkVec(lit(1), lit(2), alu(8), alu(7), alu(6), HLT, 0, 12'hFFF, 0, 16'd2, 5'd2, 0, 1, 0, 12'd5);
        vecs[8]  = mkVec(alu(0), HLT, 0, 0, 0, 0, 0, 12'hFFF, 0, 16'd0, 5'd0, 0, 0, 1, 12'd0);
        vecs[9]  = mkVec(lit(0), jmp(1, 12'h0A5), HLT, 0, 0, 0, 0, 12'h0A5, HLT, 16'd0, 5'd1, 0, 1, 0, 12'h0A5);
        vecs[10] = mkVec(lit(0), jmp(2, 12'h050), HLT, 0, 0, 0, 0, 12'h050, HLT, 16'd0, 5'd1, 0, 1, 0, 12'd2);
        vecs[11] = mkVec(jmp(1, 12'h010), HLT, 0, 0, 0, 0, 0, 12'h010, HLT, 16'd0, 5'd0, 0, 0, 1, 12'd0);
        vecs[12] = mkVec(lit(16'h8000), jmp(3, 12'h020), HLT, 0, 0, 0, 0, 12'h020, HLT, 16'h8000, 5'd1, 0, 1, 0, 12'h020);
        vecs[13] = mkVec(lit(16'hFFFF), lit(1), alu(0), jmp(4, 12'h030), HLT, 0, 0, 12'h030, HLT, 16'd0, 5'd1, 1, 1, 0, 12'h030);
        vecs[14] = mkVec(jmp(5, 12'h040), HLT, 0, 0, 0, 0, 0, 12'h040, HLT, 16'd0, 5'd0, 0, 1, 0, 12'd1);
        vecs[15] = mkVec(lit(1), alu(8), HLT, 0, 0, 0, 0, 12'hFFF, 0, 16'd1, 5'd1, 0, 0, 1, 12'd1);
        vecs[16] = mkVec(SNOP, HLT, 0, 0, 0, 0, 0, 12'hFFF, 0, 16'd0, 5'd0, 0, 1, 0, 12'd1);
        vecs[17] = mkVec(lit(4), alu(9), HLT, 0, 0, 0, 0, 12'hFFF, 0, 16'd4, 5'd1, 0, 1, 0, 12'd2);
        vecs[18] = mkVec(alu(7), HLT, 0, 0, 0, 0, 0, 12'hFFF, 0, 16'd0, 5'd0, 0, 0, 1, 12'd0);
        vecs[19] = mkVec(lit(16'h8000), lit(16'h8000), alu(5), HLT, 0, 0, 0, 12'hFFF, 0, 16'd0, 5'd1, 1, 1, 0, 12'd3);
        vecs[20] = mkVec(jmp(0, 12'h123), lit(9), HLT, 0, 0, 0, 0, 12'h123, HLT, 16'd0, 5'd0, 0, 1, 0, 12'h123);
        vecs[21] = mkVec(lit(16'hFFFF), lit(1), alu(0), lit(3), alu(2), HLT, 0, 12'hFFF, 0, 16'd0, 5'd1, 1, 1, 0, 12'd5);

        for (int i = 0; i < NVEC; i++) applyStimulus(i);

        // Exact cycle count: three instructions with zero-wait ack take six edges.
        clearMem();
        ackOn = 1'b1;
        progMem[0] = lit(5); progMem[1] = lit(7); progMem[2] = alu(0);
        applyReset();
        repeat (6) @(negedge i_clock);
        checkOutput("t6.top", {16'b0, o_top}, 32'd12);
        checkOutput("t6.count", {27'b0, o_count}, 32'd1);
        checkOutput("t6.carry", {31'b0, o_carry}, 32'd0);
        checkOutput("t6.addr", {20'b0, o_imem_addr}, 32'd3);

        // Withheld acknowledge keeps the core parked in FETCH.
        clearMem();
        progMem[0] = lit(5);
        ackOn = 1'b0;
        applyReset();
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clock);
            checkOutput("stall.req", {31'b0, o_imem_req}, 32'd1);
            checkOutput("stall.addr", {20'b0, o_imem_addr}, 32'd0);
            checkOutput("stall.count", {27'b0, o_count}, 32'd0);
        end
        ackOn = 1'b1;
        repeat (2) @(negedge i_clock);
        checkOutput("stall.top", {16'b0, o_top}, 32'd5);
        checkOutput("stall.doneCount", {27'b0, o_count}, 32'd1);
        checkOutput("stall.doneAddr", {20'b0, o_imem_addr}, 32'd1);

        // Seventeen pushes overflow a sixteen-entry stack.
        clearMem();
        for (int k = 0; k < 17; k++) progMem[k] = lit(16'(k + 1));
        applyReset();
        waitDone(200);
        checkOutput("ovf.fault", {31'b0, o_fault}, 32'd1);
        checkOutput("ovf.count", {27'b0, o_count}, 32'd16);
        checkOutput("ovf.top", {16'b0, o_top}, 32'd16);
        checkOutput("ovf.addr", {20'b0, o_imem_addr}, 32'd16);
        repeat (3) @(negedge i_clock);
        checkOutput("ovf.req", {31'b0, o_imem_req}, 32'd0);

        // Instruction pointer wraps from the last address to zero.
        clearMem();
        progMem[0] = jmp(0, 12'hFFF);
        progMem[12'hFFF] = SNOP;
        applyReset();
        repeat (2) @(negedge i_clock);
        checkOutput("wrap.jmpAddr", {20'b0, o_imem_addr}, 32'hFFF);
        repeat (2) @(negedge i_clock);
        checkOutput("wrap.addr", {20'b0, o_imem_addr}, 32'd0);

        // Reset asserted during EXEC of HALT aborts it.
        clearMem();
        progMem[0] = HLT;
        applyReset();
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        checkOutput("rstExec.halted", {31'b0, o_halted}, 32'd0);
        checkOutput("rstExec.fault", {31'b0, o_fault}, 32'd0);
        i_reset = 1'b0;
        #1;
        checkOutput("rstExec.req", {31'b0, o_imem_req}, 32'd1);
        checkOutput("rstExec.addr", {20'b0, o_imem_addr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
